// File: rtl/alu_commit_if.sv
// Handshake bundle between two ALU channels, commit buffer and register file.
// master: ALU / register-file side; slave: alu_commit.
interface alu_commit_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]       a0_res;
    logic [XLEN-1:0]       a1_res;
    logic [REG_ADDR_W-1:0] a0_rd;
    logic [REG_ADDR_W-1:0] a1_rd;
    logic                  a0_valid;
    logic                  a1_valid;
    logic                  a0_error;
    logic                  a1_error;
    logic                  a0_clear;
    logic                  a1_clear;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  wr_ready;
    logic                  err_pulse;
    logic [7:0]            err_count;
    logic [OCC_W-1:0]      occupancy;

    modport master (
        output a0_res, a1_res, a0_rd, a1_rd,
        output a0_valid, a1_valid, a0_error, a1_error,
        input  a0_clear, a1_clear,
        input  wr_en, wr_addr, wr_data,
        output wr_ready,
        input  err_pulse, err_count, occupancy
    );

    modport slave (
        input  a0_res, a1_res, a0_rd, a1_rd,
        input  a0_valid, a1_valid, a0_error, a1_error,
        output a0_clear, a1_clear,
        output wr_en, wr_addr, wr_data,
        input  wr_ready,
        output err_pulse, err_count, occupancy
    );
endinterface

// File: rtl/alu_commit.sv
// Two-channel ALU result commit buffer: round-robin arbiter into a FIFO that
// retires to the register file. Ports: clk, rst_n (sync, active-low), bus (slave).
package core_config_pkg;
    parameter int XLEN       = 32;
    parameter int REG_ADDR_W = 5;
endpackage

module alu_commit #(
    parameter int XLEN       = core_config_pkg::XLEN,
    parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W,
    parameter int DEPTH      = 4
) (
    input logic         clk,
    input logic         rst_n,
    alu_commit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]       mem_res [DEPTH];
    logic [REG_ADDR_W-1:0] mem_rd  [DEPTH];
    logic [DEPTH-1:0]      mem_err;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             prio;
    logic             err_pulse_q;
    logic [7:0]       err_count_q;

    logic                  elig0;
    logic                  elig1;
    logic                  grant0;
    logic                  grant1;
    logic                  push;
    logic                  pop;
    logic                  not_empty;
    logic                  head_err;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_res;
    logic                  head_write;

    assign not_empty = (count != '0);

    // Room is judged on the start-of-cycle count; a same-cycle pop does not help.
    assign elig0 = rst_n & bus.a0_valid & (count < CNT_W'(DEPTH));
    assign elig1 = rst_n & bus.a1_valid & (count < CNT_W'(DEPTH));

    assign grant0 = elig0 & (~elig1 | ~prio);
    assign grant1 = elig1 & (~elig0 | prio);
    assign push   = grant0 | grant1;

    assign bus.a0_clear = grant0;
    assign bus.a1_clear = grant1;

    assign head_err   = mem_err[rd_ptr];
    assign head_rd    = mem_rd[rd_ptr];
    assign head_res   = mem_res[rd_ptr];

    // Only real, error-free, non-x0 heads need the register file.
    assign head_write = ~head_err & (head_rd != '0);

    assign bus.wr_en   = rst_n & not_empty & head_write;
    assign bus.wr_addr = not_empty ? head_rd : '0;
    assign bus.wr_data = not_empty ? head_res : '0;

    assign pop = rst_n & not_empty & (~head_write | bus.wr_ready);

    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.occupancy = count;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_res[wr_ptr] <= grant1 ? bus.a1_res : bus.a0_res;
            mem_rd[wr_ptr]  <= grant1 ? bus.a1_rd : bus.a0_rd;
            mem_err[wr_ptr] <= grant1 ? bus.a1_error : bus.a0_error;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            prio        <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // Priority passes to the channel that lost (or was idle).
            if (grant0) begin
                prio <= 1'b1;
            end else if (grant1) begin
                prio <= 1'b0;
            end
            err_pulse_q <= pop & head_err;
            if (pop && head_err && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_commit.sv
// Randomised + directed bench for alu_commit against a queue-based model.
module tb_alu_commit;
    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 4;

    typedef struct {
        logic            err;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] res;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_commit_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .DEPTH(DEPTH)) bus ();

    alu_commit #(
        .XLEN(XLEN),
        .REG_ADDR_W(RW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    ent_t q[$];
    ent_t pend_e[2];
    bit   pend[2];
    bit   prio;
    int   ecnt;
    bit   epulse;
    int   compared;
    int   mismatched;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.a0_valid = pend[0];
        bus.a0_res   = pend_e[0].res;
        bus.a0_rd    = pend_e[0].rd;
        bus.a0_error = pend_e[0].err;
        bus.a1_valid = pend[1];
        bus.a1_res   = pend_e[1].res;
        bus.a1_rd    = pend_e[1].rd;
        bus.a1_error = pend_e[1].err;
    endtask

    task automatic drop();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
    endtask

    task automatic set_pend(input int c, input bit err, input logic [RW-1:0] rd,
                            input logic [XLEN-1:0] res);
        pend[c]       = 1'b1;
        pend_e[c].err = err;
        pend_e[c].rd  = rd;
        pend_e[c].res = res;
    endtask

    // One clock cycle: new ALU results, compare at negedge, advance model.
    task automatic tick(input int pv, input bit [1:0] mask, input int pr,
                        input int pe, input int pz, input bit rst);
        bit   e0, e1, g0, g1, pop, we;
        ent_t h;
        for (int c = 0; c < 2; c++) begin
            if (!pend[c] && mask[c] && $urandom_range(99) < pv) begin
                pend[c]       = 1'b1;
                pend_e[c].res = $urandom;
                pend_e[c].err = ($urandom_range(99) < pe);
                pend_e[c].rd  = ($urandom_range(99) < pz) ? 5'd0
                                : 5'($urandom_range(31, 1));
            end
        end
        drive();
        bus.wr_ready = ($urandom_range(99) < pr);
        rst_n = !rst;
        @(negedge clk);
        e0 = !rst && pend[0] && q.size() < DEPTH;
        e1 = !rst && pend[1] && q.size() < DEPTH;
        g0 = e0 && (!e1 || !prio);
        g1 = e1 && !g0;
        pop = 1'b0;
        we = 1'b0;
        h = '{err: 1'b0, rd: '0, res: '0};
        if (q.size() > 0) begin
            h = q[0];
            we = !rst && !h.err && h.rd != 0;
            pop = !rst && (h.err || h.rd == 0 || bus.wr_ready);
        end
        check("a0_clear", 32'(bus.a0_clear), 32'(g0));
        check("a1_clear", 32'(bus.a1_clear), 32'(g1));
        check("wr_en", 32'(bus.wr_en), 32'(we));
        check("occupancy", 32'(bus.occupancy), 32'(q.size()));
        check("err_pulse", 32'(bus.err_pulse), 32'(epulse));
        check("err_count", 32'(bus.err_count), 32'(ecnt));
        if (q.size() > 0 && !rst) begin
            check("wr_addr", 32'(bus.wr_addr), 32'(h.rd));
            check("wr_data", bus.wr_data, h.res);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            prio = 1'b0;
            ecnt = 0;
            epulse = 1'b0;
        end else begin
            epulse = pop && h.err;
            if (pop && h.err && ecnt < 255) ecnt++;
            if (pop) void'(q.pop_front());
            if (g0) begin
                q.push_back(pend_e[0]);
                pend[0] = 1'b0;
                prio = 1'b1;
            end else if (g1) begin
                q.push_back(pend_e[1]);
                pend[1] = 1'b0;
                prio = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        prio = 1'b0;
        ecnt = 0;
        epulse = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        pend_e[0] = '{err: 1'b0, rd: '0, res: '0};
        pend_e[1] = '{err: 1'b0, rd: '0, res: '0};
        drive();
        bus.wr_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);

        // Results pending while in reset must not be granted.
        repeat (2) tick(100, 2'b11, 100, 0, 0, 1'b1);

        // Single write to x5.
        drop();
        tick(0, 2'b00, 100, 0, 0, 1'b1);
        set_pend(0, 1'b0, 5'd5, 32'h0000_0010);
        tick(0, 2'b00, 100, 0, 0, 1'b0);
        tick(0, 2'b00, 100, 0, 0, 1'b0);
        check("single_occ", 32'(bus.occupancy), 32'd0);

        // Contention after reset.
        tick(0, 2'b00, 100, 0, 0, 1'b1);
        repeat (4) tick(100, 2'b11, 100, 0, 0, 1'b0);

        // Random mixes.
        repeat (200) tick(60, 2'b11, 50, 15, 15, 1'b0);
        repeat (200) tick(90, 2'b11, 20, 5, 5, 1'b0);
        repeat (200) tick(30, 2'b11, 90, 30, 20, 1'b0);

        // Backpressure to full, then drain.
        drop();
        tick(0, 2'b00, 0, 0, 0, 1'b1);
        repeat (8) tick(100, 2'b11, 0, 0, 0, 1'b0);
        check("full_occ", 32'(bus.occupancy), 32'd4);
        repeat (10) tick(100, 2'b01, 100, 0, 0, 1'b0);

        // x0 and error discards under wr_ready=0.
        drop();
        tick(0, 2'b00, 0, 0, 0, 1'b1);
        set_pend(0, 1'b0, 5'd0, 32'h1234_5678);
        set_pend(1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        repeat (4) tick(0, 2'b00, 0, 0, 0, 1'b0);
        check("discard_err_count", 32'(bus.err_count), 32'd1);
        check("discard_occ", 32'(bus.occupancy), 32'd0);

        // Saturating error counter.
        repeat (300) tick(100, 2'b11, 50, 100, 0, 1'b0);
        check("sat_err_count", 32'(bus.err_count), 32'd255);

        // Mid-operation reset with three buffered entries.
        drop();
        repeat (6) tick(0, 2'b00, 0, 0, 0, 1'b0);
        repeat (3) tick(100, 2'b01, 0, 0, 0, 1'b0);
        check("pre_rst_occ", 32'(bus.occupancy), 32'd3);
        drop();
        tick(0, 2'b00, 0, 0, 0, 1'b1);
        check("post_rst_occ", 32'(bus.occupancy), 32'd0);
        check("post_rst_err_count", 32'(bus.err_count), 32'd0);
        check("post_rst_wr_en", 32'(bus.wr_en), 32'd0);

        repeat (100) tick(70, 2'b11, 60, 10, 10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
